bar_peak_hold: RTL and testbench
================================

# bar_peak_hold

Per-column level-decay and peak-hold stage that sits directly downstream of the linear spectrum complementer and consumes its 7-bit interpolated bars, one column per valid strobe. It keeps per-column state (smoothed level, peak dot, hold counter) in an internal array and emits the displayed bar height plus peak-dot height for the renderer. After reset, an internal sweep clears the state array before any column is accepted.

## Interface
- NCOL, 64: columns per frame; legal range 2..128.
- DECAY, 2: level fall per frame, in bar units.
- HOLD_FRAMES, 30: frames a new peak is held before it starts falling; legal range 0..63.
- Clock  in  1  system clock; all logic on its rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- FrameStart  in  1  level trigger; a 0->1 transition, detected against a registered copy, starts a new frame.
- Valid  in  1  one-cycle strobe; InBar holds the bar for the current column.
- Thru  in  1  bypass; sampled together with Valid.
- InBar  in  7  bar height from the complementer.
- OutBar  out  7  displayed level.
- OutPeak  out  7  peak-dot height.
- OutCol  out  7  column index of the OutBar/OutPeak pair.
- OutValid  out  1  one-cycle strobe; outputs are valid.
- Busy  out  1  high during the init sweep or while a column is in flight.
- Overrun  out  1  sticky; more than NCOL strobes arrived in the current frame.

## Operation
- State array entry per column: Level[6:0], Peak[6:0], Hold[5:0]. Synchronous read, one write port.
- FSM states:
  - INIT: write zeros to addresses 0..NCOL-1, one per cycle. Valid is ignored and does not set Overrun. Go to RUN after address NCOL-1.
  - RUN: normal processing.
- Column counter Col:
  - Cleared to 0 on a FrameStart edge; the edge also clears Overrun.
  - Increments on each accepted Valid and saturates at NCOL.
  - Valid with Col==NCOL: dropped; Overrun set to 1; no output, no write.
- Compute, normal path:
  - L' = max(InBar, Level-DECAY), with the subtraction saturating at 0.
  - If InBar >= Peak: P'=InBar, H'=HOLD_FRAMES.
  - Else if Hold!=0: P'=Peak, H'=Hold-1.
  - Else: P'=max(Peak-1, L'), H'=0.
- Compute, Thru path: L'=P'=InBar, H'=0. Keeps state coherent when Thru is released.
- Outputs: OutBar=L', OutPeak=P', OutCol=column index. The write-back uses the same values.
- All arithmetic is 8-bit unsigned internally; results are always within 0..127, no wrap.

## Timing
- Reset values: OutBar=0, OutPeak=0, OutCol=0, OutValid=0, Overrun=0, Busy=1. FSM=INIT, Col=0.
- Busy stays 1 for exactly NCOL cycles after Reset_n deasserts, then follows the in-flight flag.
- Valid accepted in cycle t:
  - t: array read issued.
  - t+1: compute, and write at the end of t+1.
  - OutValid=1 in cycle t+2.
- Latency is 2 cycles; full throughput of one column per cycle, with no stall and no backpressure.
- No read/write hazard: back-to-back strobes always address different columns (NCOL>=2).
- FrameStart edge and Valid in the same cycle: counter clear wins, and that Valid is processed as column 0.
- FrameStart edge while columns are in flight: in-flight columns complete normally with their original indices.
- Busy = INIT | stage1 valid | stage2 valid.
- Reset_n asserted mid-frame or mid-INIT: outputs return to reset values immediately; the INIT sweep restarts from address 0 after release.

## Configuration
- BAR_PEAK_HOLD_PEAK_EN defined:
  - Peak and Hold fields are stored and computed as above.
- Not defined:
  - Peak and Hold storage and logic are removed.
  - OutPeak is tied to 0.
  - Level path, latency, and all other outputs are unchanged.

## Test plan
- Reset release, NCOL=64: Busy=1 for 64 cycles. A Valid at cycle 10 produces no OutValid and leaves Overrun=0.
- Frame, InBar=100, col 0: OutBar=100, OutPeak=100 at t+2, OutCol=0. Next frames with InBar=0 give OutBar 98, 96, 94... and OutPeak held at 100 for 30 frames, then 99.
- Thru=1 with InBar=50 on col 3 (stored Level=120): OutBar=OutPeak=50. Next frame with Thru=0 and InBar=0: OutBar=48.
- 65 strobes in one frame: 64 OutValid pulses and Overrun=1 after strobe 65. Next FrameStart edge clears Overrun.
- FrameStart edge coincident with Valid (InBar=7): OutCol=0, OutBar=7.
- Reset_n pulsed low mid-frame: all outputs 0 at once, Busy=1, full 64-cycle INIT rerun. With BAR_PEAK_HOLD_PEAK_EN undefined, OutPeak=0 throughout.

Source files
------------

// File: rtl/bar_peak_hold.sv
// Per-column level decay and peak-hold stage with an internal state array cleared by a post-reset sweep.
// Optional feature macro: BAR_PEAK_HOLD_PEAK_EN enables peak/hold storage; undefined ties OutPeak to 0.
module bar_peak_hold #(
    parameter int NCOL        = 64,
    parameter int DECAY       = 2,
    parameter int HOLD_FRAMES = 30
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       FrameStart,
    input  logic       Valid,
    input  logic       Thru,
    input  logic [6:0] InBar,
    output logic [6:0] OutBar,
    output logic [6:0] OutPeak,
    output logic [6:0] OutCol,
    output logic       OutValid,
    output logic       Busy,
    output logic       Overrun
);

    localparam int              AW        = $clog2(NCOL);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(NCOL - 1);
    localparam logic [7:0]      NCOL_W    = 8'(NCOL);
    localparam logic [7:0]      DECAY_W   = 8'(DECAY);
    localparam logic [0:0]      ST_INIT   = 1'b0;
    localparam logic [0:0]      ST_RUN    = 1'b1;
`ifdef BAR_PEAK_HOLD_PEAK_EN
    localparam logic [5:0]      HOLD_W    = 6'(HOLD_FRAMES);
    localparam int              EW        = 20;
`else
    localparam int              EW        = 7;
`endif

    function automatic logic [6:0] sat_sub7(input logic [6:0] a, input logic [7:0] b);
        if ({1'b0, a} >= b) begin
            sat_sub7 = 7'({1'b0, a} - b);
        end else begin
            sat_sub7 = 7'd0;
        end
    endfunction

    function automatic logic [6:0] max7(input logic [6:0] a, input logic [6:0] b);
        if (a >= b) begin
            max7 = a;
        end else begin
            max7 = b;
        end
    endfunction

    logic [0:0]    fsm_r;
    logic [AW-1:0] init_addr_r;
    logic          fs_d_r;
    logic [7:0]    col_r;
    logic          overrun_r;
    logic          s1_vld_r;
    logic [6:0]    s1_col_r;
    logic [6:0]    s1_bar_r;
    logic          s1_thru_r;
    logic [EW-1:0] rd_data_r;
    logic [EW-1:0] mem_r [NCOL];
    logic          out_valid_r;
    logic [6:0]    out_bar_r;
    logic [6:0]    out_col_r;

    logic          fs_edge_s;
    logic          run_s;
    logic          accept_s;
    logic          drop_s;
    logic [7:0]    col_eff_s;
    logic [7:0]    col_nxt_s;
    logic          overrun_nxt_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_addr_s;
    logic [AW-1:0] rd_addr_s;
    logic [EW-1:0] wr_data_s;
    logic [6:0]    new_level_s;
    logic [6:0]    dec_level_s;
`ifdef BAR_PEAK_HOLD_PEAK_EN
    logic [6:0]    new_peak_s;
    logic [5:0]    new_hold_s;
    logic [6:0]    cur_peak_s;
    logic [5:0]    cur_hold_s;
    logic [6:0]    out_peak_r;
`endif

    // Column acceptance: a FrameStart edge clears the counter before this cycle's Valid is judged.
    always_comb begin
        fs_edge_s = FrameStart & ~fs_d_r;
        run_s     = (fsm_r == ST_RUN);
        if (fs_edge_s) begin
            col_eff_s = 8'd0;
        end else begin
            col_eff_s = col_r;
        end
        accept_s = run_s & Valid & (col_eff_s < NCOL_W);
        drop_s   = run_s & Valid & ~(col_eff_s < NCOL_W);
        rd_addr_s = AW'(col_eff_s);
        if (accept_s) begin
            col_nxt_s = col_eff_s + 8'd1;
        end else begin
            col_nxt_s = col_eff_s;
        end
        if (fs_edge_s) begin
            overrun_nxt_s = 1'b0;
        end else if (drop_s) begin
            overrun_nxt_s = 1'b1;
        end else begin
            overrun_nxt_s = overrun_r;
        end
    end

    // Level and peak update for the column read in the previous cycle.
    always_comb begin
        dec_level_s = max7(s1_bar_r, sat_sub7(rd_data_r[6:0], DECAY_W));
        if (s1_thru_r) begin
            new_level_s = s1_bar_r;
        end else begin
            new_level_s = dec_level_s;
        end
`ifdef BAR_PEAK_HOLD_PEAK_EN
        cur_peak_s = rd_data_r[13:7];
        cur_hold_s = rd_data_r[19:14];
        if (s1_thru_r) begin
            new_peak_s = s1_bar_r;
            new_hold_s = 6'd0;
        end else if (s1_bar_r >= cur_peak_s) begin
            new_peak_s = s1_bar_r;
            new_hold_s = HOLD_W;
        end else if (cur_hold_s != 6'd0) begin
            new_peak_s = cur_peak_s;
            new_hold_s = cur_hold_s - 6'd1;
        end else begin
            new_peak_s = max7(sat_sub7(cur_peak_s, 8'd1), dec_level_s);
            new_hold_s = 6'd0;
        end
`endif
    end

    // Single write port: zeros during the init sweep, computed entry otherwise.
    always_comb begin
        if (fsm_r == ST_INIT) begin
            wr_en_s   = 1'b1;
            wr_addr_s = init_addr_r;
            wr_data_s = {EW{1'b0}};
        end else begin
            wr_en_s   = s1_vld_r;
            wr_addr_s = AW'(s1_col_r);
`ifdef BAR_PEAK_HOLD_PEAK_EN
            wr_data_s = {new_hold_s, new_peak_s, new_level_s};
`else
            wr_data_s = new_level_s;
`endif
        end
    end

    // State array; a same-cycle write to the read address is forwarded to keep the read coherent.
    always_ff @(posedge Clock) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
        if (accept_s) begin
            if (wr_en_s && (wr_addr_s == rd_addr_s)) begin
                rd_data_r <= wr_data_s;
            end else begin
                rd_data_r <= mem_r[rd_addr_s];
            end
        end
    end

    // Control: init sweep, column counter, overrun flag and stage-1 capture.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            fsm_r       <= ST_INIT;
            init_addr_r <= {AW{1'b0}};
            fs_d_r      <= 1'b0;
            col_r       <= 8'd0;
            overrun_r   <= 1'b0;
            s1_vld_r    <= 1'b0;
            s1_col_r    <= 7'd0;
            s1_bar_r    <= 7'd0;
            s1_thru_r   <= 1'b0;
        end else begin
            fs_d_r   <= FrameStart;
            s1_vld_r <= accept_s;
            if (accept_s) begin
                s1_col_r  <= col_eff_s[6:0];
                s1_bar_r  <= InBar;
                s1_thru_r <= Thru;
            end
            case (fsm_r)
                ST_INIT: begin
                    if (init_addr_r == LAST_ADDR) begin
                        init_addr_r <= {AW{1'b0}};
                        fsm_r       <= ST_RUN;
                    end else begin
                        init_addr_r <= init_addr_r + AW'(1);
                    end
                end
                ST_RUN: begin
                    col_r     <= col_nxt_s;
                    overrun_r <= overrun_nxt_s;
                end
                default: begin
                    fsm_r       <= ST_INIT;
                    init_addr_r <= {AW{1'b0}};
                end
            endcase
        end
    end

    // Output register stage.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_r <= 1'b0;
            out_bar_r   <= 7'd0;
            out_col_r   <= 7'd0;
`ifdef BAR_PEAK_HOLD_PEAK_EN
            out_peak_r  <= 7'd0;
`endif
        end else begin
            out_valid_r <= s1_vld_r;
            if (s1_vld_r) begin
                out_bar_r  <= new_level_s;
                out_col_r  <= s1_col_r;
`ifdef BAR_PEAK_HOLD_PEAK_EN
                out_peak_r <= new_peak_s;
`endif
            end
        end
    end

    assign OutBar   = out_bar_r;
    assign OutCol   = out_col_r;
    assign OutValid = out_valid_r;
    assign Overrun  = overrun_r;
    assign Busy     = (fsm_r == ST_INIT) | s1_vld_r | out_valid_r;
`ifdef BAR_PEAK_HOLD_PEAK_EN
    assign OutPeak  = out_peak_r;
`else
    assign OutPeak  = 7'd0;
`endif

endmodule

// File: tb/tb_bar_peak_hold.sv
// Directed self-checking bench for bar_peak_hold (NCOL=64, DECAY=2, HOLD_FRAMES=30).
// Expected peak values follow BAR_PEAK_HOLD_PEAK_EN; with it undefined OutPeak must stay 0.
module tb_bar_peak_hold;

    logic       Clock;
    logic       Reset_n;
    logic       FrameStart;
    logic       Valid;
    logic       Thru;
    logic [6:0] InBar;
    logic [6:0] OutBar;
    logic [6:0] OutPeak;
    logic [6:0] OutCol;
    logic       OutValid;
    logic       Busy;
    logic       Overrun;

    int tests_run;
    int tests_failed;
    int ov_cnt;
    int peak_nz;
    int ov_base;

`ifdef BAR_PEAK_HOLD_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    bar_peak_hold #(.NCOL(64), .DECAY(2), .HOLD_FRAMES(30)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .FrameStart (FrameStart),
        .Valid      (Valid),
        .Thru       (Thru),
        .InBar      (InBar),
        .OutBar     (OutBar),
        .OutPeak    (OutPeak),
        .OutCol     (OutCol),
        .OutValid   (OutValid),
        .Busy       (Busy),
        .Overrun    (Overrun)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        ov_cnt  = 0;
        peak_nz = 0;
    end

    // Output strobe and peak monitors, sampled on the inactive edge.
    always @(negedge Clock) begin
        if (OutValid) ov_cnt <= ov_cnt + 1;
        if (OutPeak != 7'd0) peak_nz <= peak_nz + 1;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        tests_run = tests_run + 1;
        if (got != exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_pk(input int v);
        return PEAK_EN ? v : 0;
    endfunction

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic frame_start;
        FrameStart = 1'b1;
        tick();
        FrameStart = 1'b0;
        tick();
    endtask

    task automatic strobe(input logic [6:0] bar, input logic thru);
        Valid = 1'b1;
        InBar = bar;
        Thru  = thru;
        tick();
        Valid = 1'b0;
        Thru  = 1'b0;
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Reset_n      = 1'b0;
        FrameStart   = 1'b0;
        Valid        = 1'b0;
        Thru         = 1'b0;
        InBar        = 7'd0;
        repeat (3) tick();

        // Reset values and init sweep length
        check_val("rst_outbar", OutBar, 0);
        check_val("rst_outpeak", OutPeak, 0);
        check_val("rst_outcol", OutCol, 0);
        check_val("rst_outvalid", OutValid, 0);
        check_val("rst_overrun", Overrun, 0);
        check_val("rst_busy", Busy, 1);
        ov_base = ov_cnt;
        Reset_n = 1'b1;
        repeat (10) tick();
        Valid = 1'b1;
        InBar = 7'd55;
        tick();
        Valid = 1'b0;
        repeat (52) tick();
        check_val("init_busy_63", Busy, 1);
        tick();
        check_val("init_busy_64", Busy, 0);
        repeat (3) tick();
        check_val("init_valid_ignored", ov_cnt - ov_base, 0);
        check_val("init_no_overrun", Overrun, 0);

        // Peak hold and level decay on column 0
        frame_start();
        Valid = 1'b1;
        InBar = 7'd100;
        tick();
        Valid = 1'b0;
        check_val("busy_inflight", Busy, 1);
        tick();
        check_val("f0_outvalid", OutValid, 1);
        check_val("f0_outbar", OutBar, 100);
        check_val("f0_outpeak", OutPeak, exp_pk(100));
        check_val("f0_outcol", OutCol, 0);
        tick();
        check_val("busy_idle", Busy, 0);
        for (int k = 1; k <= 35; k++) begin
            frame_start();
            strobe(7'd0, 1'b0);
            check_val("decay_bar", OutBar, (100 - 2 * k > 0) ? 100 - 2 * k : 0);
            check_val("decay_peak", OutPeak, exp_pk((k <= 30) ? 100 : 100 - (k - 30)));
        end

        // Thru bypass on column 3
        frame_start();
        repeat (3) strobe(7'd0, 1'b0);
        strobe(7'd120, 1'b0);
        check_val("thru_setup_col", OutCol, 3);
        check_val("thru_setup_bar", OutBar, 120);
        frame_start();
        repeat (3) strobe(7'd0, 1'b0);
        strobe(7'd50, 1'b1);
        check_val("thru_col", OutCol, 3);
        check_val("thru_bar", OutBar, 50);
        check_val("thru_peak", OutPeak, exp_pk(50));
        frame_start();
        repeat (3) strobe(7'd0, 1'b0);
        strobe(7'd0, 1'b0);
        check_val("post_thru_bar", OutBar, 48);
        check_val("post_thru_peak", OutPeak, exp_pk(49));

        // 65 back-to-back strobes in one frame
        frame_start();
        ov_base = ov_cnt;
        Valid = 1'b1;
        InBar = 7'd127;
        repeat (64) tick();
        check_val("ovr_before", Overrun, 0);
        check_val("stream_valid", OutValid, 1);
        tick();
        check_val("ovr_after", Overrun, 1);
        check_val("stream_last_col", OutCol, 63);
        check_val("stream_last_bar", OutBar, 127);
        check_val("stream_last_peak", OutPeak, exp_pk(127));
        Valid = 1'b0;
        tick();
        check_val("dropped_no_out", OutValid, 0);
        tick();
        check_val("stream_count", ov_cnt - ov_base, 64);
        frame_start();
        check_val("ovr_cleared", Overrun, 0);

        // Reset mid-frame, then again mid-init
        Valid = 1'b1;
        InBar = 7'd100;
        repeat (66) tick();
        Valid = 1'b0;
        check_val("pre_rst_overrun", Overrun, 1);
        check_val("pre_rst_col", OutCol, 63);
        check_val("pre_rst_bar", OutBar, 125);
        check_val("pre_rst_peak", OutPeak, exp_pk(127));
        Reset_n = 1'b0;
        #1;
        check_val("mid_rst_bar", OutBar, 0);
        check_val("mid_rst_peak", OutPeak, 0);
        check_val("mid_rst_col", OutCol, 0);
        check_val("mid_rst_valid", OutValid, 0);
        check_val("mid_rst_overrun", Overrun, 0);
        check_val("mid_rst_busy", Busy, 1);
        tick();
        Reset_n = 1'b1;
        repeat (20) tick();
        check_val("reinit_busy_20", Busy, 1);
        Reset_n = 1'b0;
        #1;
        check_val("reinit_rst_busy", Busy, 1);
        tick();
        Reset_n = 1'b1;
        repeat (63) tick();
        check_val("reinit_busy_63", Busy, 1);
        tick();
        check_val("reinit_busy_64", Busy, 0);

        // FrameStart edge coincident with Valid
        frame_start();
        strobe(7'd0, 1'b0);
        strobe(7'd0, 1'b0);
        FrameStart = 1'b1;
        Valid      = 1'b1;
        InBar      = 7'd7;
        tick();
        FrameStart = 1'b0;
        Valid      = 1'b0;
        tick();
        check_val("coinc_valid", OutValid, 1);
        check_val("coinc_col", OutCol, 0);
        check_val("coinc_bar", OutBar, 7);
        check_val("coinc_peak", OutPeak, exp_pk(7));
        strobe(7'd9, 1'b0);
        check_val("coinc_next_col", OutCol, 1);
        check_val("coinc_next_bar", OutBar, 9);
        tick();
`ifndef BAR_PEAK_HOLD_PEAK_EN
        check_val("peak_tied_zero", peak_nz, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
